// File: rtl/hsv_pkg.sv
// hsv_pkg: shared definitions for the HSV pixel path.
// Holds the pixel/coordinate/accumulator widths, the centroid FSM state
// type and the hue window test shared with the pipette logic.
`timescale 1ns/1ps
package hsv_pkg;

  localparam int unsigned HUE_W     = 9;
  localparam int unsigned SV_W      = 5;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned CNT_W     = 19;
  localparam int unsigned SUM_W     = 28;
  localparam int unsigned DIV_CNT_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIV_X  = 2'd1,
    DIV_Y  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Inclusive hue window; when lo > hi the window wraps through 0.
  function automatic logic hue_in_window(input logic [HUE_W-1:0] hue,
                                         input logic [HUE_W-1:0] lo,
                                         input logic [HUE_W-1:0] hi);
    if (lo > hi) return (hue >= lo) || (hue <= hi);
    else         return (hue >= lo) && (hue <= hi);
  endfunction

endpackage

// File: rtl/serial_div.sv
// serial_div: restoring unsigned divider, one quotient bit per cycle.
// The cycle with i_start high is the first iteration (operands are taken
// straight from the inputs); o_done marks the last iteration and o_quotient
// is the final quotient in that cycle. Total latency SUM_W cycles.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_start      begin a division (only while !o_busy)
//   i_dividend   SUM_W-bit dividend
//   i_divisor    CNT_W-bit divisor, must be non-zero
//   o_busy       iterations 2..SUM_W in progress
//   o_done       final iteration this cycle
//   o_quotient   quotient after this cycle's iteration (valid with o_done)
`timescale 1ns/1ps
module serial_div
  import hsv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [SUM_W-1:0] i_dividend,
  input  logic [CNT_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [SUM_W-1:0] o_quotient
);

  logic [CNT_W-1:0]     r_rem;
  logic [SUM_W-1:0]     r_q;
  logic [CNT_W-1:0]     r_div;
  logic [DIV_CNT_W-1:0] r_left;
  logic                 r_busy;

  logic                 w_active;
  logic [CNT_W-1:0]     w_rem_in;
  logic [SUM_W-1:0]     w_q_in;
  logic [CNT_W-1:0]     w_d;
  logic [DIV_CNT_W-1:0] w_left_now;
  logic [CNT_W:0]       w_shift;
  logic                 w_ge;
  logic [CNT_W-1:0]     w_rem_next;
  logic [SUM_W-1:0]     w_q_next;

  assign w_active   = i_start | r_busy;
  assign w_rem_in   = i_start ? '0 : r_rem;
  assign w_q_in     = i_start ? i_dividend : r_q;
  assign w_d        = i_start ? i_divisor : r_div;
  assign w_left_now = i_start ? DIV_CNT_W'(SUM_W) : r_left;

  assign w_shift  = {w_rem_in, w_q_in[SUM_W-1]};
  assign w_ge     = (w_shift >= {1'b0, w_d});
  assign w_q_next = {w_q_in[SUM_W-2:0], w_ge};

  // Remainder stays below the divisor, so it always fits CNT_W bits.
  always_comb begin
    w_rem_next = w_shift[CNT_W-1:0];
    if (w_ge) w_rem_next = CNT_W'(w_shift - {1'b0, w_d});
  end

  assign o_busy     = r_busy;
  assign o_done     = w_active && (w_left_now == DIV_CNT_W'(1));
  assign o_quotient = w_q_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_left <= '0;
      r_busy <= 1'b0;
    end else if (w_active) begin
      r_rem  <= w_rem_next;
      r_q    <= w_q_next;
      r_div  <= w_d;
      r_left <= w_left_now - DIV_CNT_W'(1);
      r_busy <= (w_left_now > DIV_CNT_W'(1));
    end
  end

  assert property (@(posedge clk) disable iff (rst) i_start |-> (i_divisor != '0));

endmodule

// File: rtl/ball_centroid.sv
// ball_centroid: per-frame centroid of pixels inside an HSV window.
// Counts matching pixels and sums their coordinates; at frame_start the
// totals are snapshotted and divided serially (X then Y) and the result is
// published with a one-cycle result_valid strobe.
// Ports:
//   clk, res           clock, asynchronous active-high reset
//   frame_start        frame boundary strobe
//   line_end           end-of-line strobe
//   pix_valid          hue/saturation/value/hue_invalid valid
//   centroid_x/_y      centroid of last reported frame (0 when !found)
//   pixel_count        matched pixels in last reported frame
//   found              pixel_count >= MIN_PIXELS
//   result_valid       one-cycle strobe, outputs updated this cycle
//   overrun            sticky, frame dropped while divider busy
// Optional: define BALL_CENTROID_BBOX_EN to add bbox_x0/x1/y0/y1 outputs
// (bounding box of matched pixels, 0 when !found).
`timescale 1ns/1ps
module ball_centroid
  import hsv_pkg::*;
#(
  parameter int unsigned HUE_LO     = 330,
  parameter int unsigned HUE_HI     = 20,
  parameter int unsigned SAT_MIN    = 12,
  parameter int unsigned VAL_MIN    = 12,
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned H_MAX      = 640,
  parameter int unsigned V_MAX      = 480
) (
  input  logic             clk,
  input  logic             res,
  input  logic             frame_start,
  input  logic             line_end,
  input  logic             pix_valid,
  input  logic [HUE_W-1:0] hue,
  input  logic             hue_invalid,
  input  logic [SV_W-1:0]  saturation,
  input  logic [SV_W-1:0]  value,
  output logic [X_W-1:0]   centroid_x,
  output logic [Y_W-1:0]   centroid_y,
  output logic [CNT_W-1:0] pixel_count,
  output logic             found,
  output logic             result_valid,
  output logic             overrun
`ifdef BALL_CENTROID_BBOX_EN
  ,
  output logic [X_W-1:0]   bbox_x0,
  output logic [X_W-1:0]   bbox_x1,
  output logic [Y_W-1:0]   bbox_y0,
  output logic [Y_W-1:0]   bbox_y1
`endif
);

  state_t r_state, w_next_state;

  logic [X_W-1:0]   r_x, w_px, w_x_inc;
  logic [Y_W-1:0]   r_y, w_py, w_y_inc;
  logic             w_match;

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_hcnt;
  logic [SUM_W-1:0] r_sx, w_sx_nxt, r_hsx;
  logic [SUM_W-1:0] r_sy, w_sy_nxt, r_hsy;

  logic             w_fs_accept;
  logic             w_snap_found;
  logic             w_div_start, w_div_busy, w_div_done;
  logic [SUM_W-1:0] w_div_dividend, w_quot;
  logic [X_W-1:0]   r_qx;

  logic [X_W-1:0]   r_cx;
  logic [Y_W-1:0]   r_cy;
  logic [CNT_W-1:0] r_pc;
  logic             r_found;
  logic             r_ovr;

  // ---------------- pixel classification and coordinates ----------------
  assign w_match = pix_valid && !hue_invalid
                && (saturation >= SV_W'(SAT_MIN))
                && (value >= SV_W'(VAL_MIN))
                && hue_in_window(hue, HUE_W'(HUE_LO), HUE_W'(HUE_HI));

  // A pixel coincident with frame_start belongs to the new frame at (0,0).
  assign w_px = frame_start ? '0 : r_x;
  assign w_py = frame_start ? '0 : r_y;

  assign w_x_inc = (r_x == X_W'(H_MAX - 1)) ? r_x : r_x + X_W'(1);
  assign w_y_inc = (r_y == Y_W'(V_MAX - 1)) ? r_y : r_y + Y_W'(1);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_x <= '0;
      r_y <= '0;
    end else if (frame_start) begin
      r_x <= pix_valid ? X_W'(1) : '0;
      r_y <= '0;
    end else if (line_end) begin
      r_x <= '0;
      r_y <= w_y_inc;
    end else if (pix_valid) begin
      r_x <= w_x_inc;
    end
  end

  // ---------------- accumulators and snapshot ----------------
  always_comb begin
    w_cnt_nxt = frame_start ? '0 : r_cnt;
    w_sx_nxt  = frame_start ? '0 : r_sx;
    w_sy_nxt  = frame_start ? '0 : r_sy;
    if (w_match) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      w_sx_nxt  = w_sx_nxt + SUM_W'(w_px);
      w_sy_nxt  = w_sy_nxt + SUM_W'(w_py);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sx  <= w_sx_nxt;
      r_sy  <= w_sy_nxt;
    end
  end

  assign w_fs_accept  = frame_start && (r_state == ACCUM);
  assign w_snap_found = (r_cnt >= CNT_W'(MIN_PIXELS));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_hcnt <= '0;
      r_hsx  <= '0;
      r_hsy  <= '0;
    end else if (w_fs_accept) begin
      r_hcnt <= r_cnt;
      r_hsx  <= r_sx;
      r_hsy  <= r_sy;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= ACCUM;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    result_valid = 1'b0;
    unique case (r_state)
      ACCUM:  if (frame_start) w_next_state = w_snap_found ? DIV_X : REPORT;
      DIV_X:  if (w_div_done) w_next_state = DIV_Y;
      DIV_Y:  if (w_div_done) w_next_state = REPORT;
      REPORT: begin
        result_valid = 1'b1;
        w_next_state = ACCUM;
      end
      default: w_next_state = ACCUM;
    endcase
  end

  // ---------------- divider ----------------
  // Busy drops for the first cycle of each DIV state, which issues start.
  assign w_div_start    = ((r_state == DIV_X) || (r_state == DIV_Y)) && !w_div_busy;
  assign w_div_dividend = (r_state == DIV_Y) ? r_hsy : r_hsx;

  serial_div u_div (
    .clk        (clk),
    .rst        (res),
    .i_start    (w_div_start),
    .i_dividend (w_div_dividend),
    .i_divisor  (r_hcnt),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res)                                  r_qx <= '0;
    else if ((r_state == DIV_X) && w_div_done) r_qx <= X_W'(w_quot);
  end

  // ---------------- outputs ----------------
  // Outputs are loaded on the edge that enters REPORT so they are already
  // stable during the result_valid cycle.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pc    <= '0;
      r_found <= 1'b0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else if (w_fs_accept && !w_snap_found) begin
      r_pc    <= r_cnt;
      r_found <= 1'b0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else if ((r_state == DIV_Y) && w_div_done) begin
      r_pc    <= r_hcnt;
      r_found <= 1'b1;
      r_cx    <= r_qx;
      r_cy    <= Y_W'(w_quot);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res)                                  r_ovr <= 1'b0;
    else if (frame_start && (r_state != ACCUM)) r_ovr <= 1'b1;
  end

  assign centroid_x  = r_cx;
  assign centroid_y  = r_cy;
  assign pixel_count = r_pc;
  assign found       = r_found;
  assign overrun     = r_ovr;

`ifdef BALL_CENTROID_BBOX_EN
  logic [X_W-1:0] r_bx0, r_bx1, r_hbx0, r_hbx1, r_obx0, r_obx1;
  logic [Y_W-1:0] r_by0, r_by1, r_hby0, r_hby1, r_oby0, r_oby1;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_bx0 <= X_W'(H_MAX - 1);
      r_by0 <= Y_W'(V_MAX - 1);
      r_bx1 <= '0;
      r_by1 <= '0;
    end else if (frame_start) begin
      if (w_match) begin
        r_bx0 <= '0;
        r_by0 <= '0;
      end else begin
        r_bx0 <= X_W'(H_MAX - 1);
        r_by0 <= Y_W'(V_MAX - 1);
      end
      r_bx1 <= '0;
      r_by1 <= '0;
    end else if (w_match) begin
      if (r_x < r_bx0) r_bx0 <= r_x;
      if (r_x > r_bx1) r_bx1 <= r_x;
      if (r_y < r_by0) r_by0 <= r_y;
      if (r_y > r_by1) r_by1 <= r_y;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_hbx0 <= X_W'(H_MAX - 1);
      r_hby0 <= Y_W'(V_MAX - 1);
      r_hbx1 <= '0;
      r_hby1 <= '0;
    end else if (w_fs_accept) begin
      r_hbx0 <= r_bx0;
      r_hby0 <= r_by0;
      r_hbx1 <= r_bx1;
      r_hby1 <= r_by1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_obx0 <= '0;
      r_obx1 <= '0;
      r_oby0 <= '0;
      r_oby1 <= '0;
    end else if (w_fs_accept && !w_snap_found) begin
      r_obx0 <= '0;
      r_obx1 <= '0;
      r_oby0 <= '0;
      r_oby1 <= '0;
    end else if ((r_state == DIV_Y) && w_div_done) begin
      r_obx0 <= r_hbx0;
      r_obx1 <= r_hbx1;
      r_oby0 <= r_hby0;
      r_oby1 <= r_hby1;
    end
  end

  assign bbox_x0 = r_obx0;
  assign bbox_x1 = r_obx1;
  assign bbox_y0 = r_oby0;
  assign bbox_y1 = r_oby1;
`endif

  assert property (@(posedge clk) MIN_PIXELS >= 1);

endmodule

// File: tb/tb_ball_centroid.sv
// Testbench for ball_centroid: directed frames, expected results queued at
// each frame_start and checked by an independent monitor on result_valid.
`timescale 1ns/1ps
module tb_ball_centroid;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       frame_start = 1'b0;
  logic       line_end = 1'b0;
  logic       pix_valid = 1'b0;
  logic [8:0] hue = '0;
  logic       hue_invalid = 1'b0;
  logic [4:0] saturation = '0;
  logic [4:0] value = '0;
  logic [9:0]  centroid_x;
  logic [8:0]  centroid_y;
  logic [18:0] pixel_count;
  logic        found;
  logic        result_valid;
  logic        overrun;

  ball_centroid dut (
    .clk          (clk),
    .res          (res),
    .frame_start  (frame_start),
    .line_end     (line_end),
    .pix_valid    (pix_valid),
    .hue          (hue),
    .hue_invalid  (hue_invalid),
    .saturation   (saturation),
    .value        (value),
    .centroid_x   (centroid_x),
    .centroid_y   (centroid_y),
    .pixel_count  (pixel_count),
    .found        (found),
    .result_valid (result_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cnt;
    int fnd;
    int cx;
    int cy;
    int ovr;
    int at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  logic prev_rv = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic drive(input logic fs, input logic le, input logic pv,
                       input logic [8:0] h, input logic hi,
                       input logic [4:0] s, input logic [4:0] v);
    frame_start = fs;
    line_end    = le;
    pix_valid   = pv;
    hue         = h;
    hue_invalid = hi;
    saturation  = s;
    value       = v;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    line_end    = 1'b0;
    pix_valid   = 1'b0;
    hue         = '0;
    hue_invalid = 1'b0;
    saturation  = '0;
    value       = '0;
  endtask

  task automatic pix(input logic [8:0] h, input logic hi,
                     input logic [4:0] s, input logic [4:0] v);
    drive(1'b0, 1'b0, 1'b1, h, hi, s, v);
  endtask

  task automatic red_pixels(input int n);
    for (int i = 0; i < n; i++) pix(9'd0, 1'b0, 5'd31, 5'd31);
  endtask

  task automatic eol();
    drive(1'b0, 1'b1, 1'b0, 9'd0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 5'd0, 5'd0);
  endtask

  // Queue the expected report for the frame closed by this frame_start.
  task automatic fs_exp(input int cnt, input int fnd, input int cx, input int cy,
                        input int ovr, input int lat, input logic pv);
    exp_t e;
    e.cnt = cnt; e.fnd = fnd; e.cx = cx; e.cy = cy; e.ovr = ovr;
    e.at  = cyc + lat;
    exp_q.push_back(e);
    drive(1'b1, 1'b0, pv, 9'd0, 1'b0, 5'd31, 5'd31);
  endtask

  // Monitor: every result_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      chk("rv_one_cycle", int'(prev_rv), 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: result_valid=1 with nothing pending, pixel_count=%0d (cycle %0d)",
                 pixel_count, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency",     cyc,               mon_e.at);
        chk("pixel_count", int'(pixel_count), mon_e.cnt);
        chk("found",       int'(found),       mon_e.fnd);
        chk("centroid_x",  int'(centroid_x),  mon_e.cx);
        chk("centroid_y",  int'(centroid_y),  mon_e.cy);
        chk("overrun",     int'(overrun),     mon_e.ovr);
      end
    end
    prev_rv = result_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 100000", cyc);
    $fatal(1, "watchdog");
  end

  int hv[13] = '{330, 359, 0, 20, 21, 329, 0, 0, 0, 0, 100, 345, 10};
  int iv[13] = '{0,   0,   0, 0,  0,  0,   1, 0, 0, 0, 0,   0,   0};
  int sv[13] = '{31,  31,  31, 31, 31, 31, 31, 12, 11, 31, 31, 20, 13};
  int vv[13] = '{31,  31,  31, 31, 31, 31, 31, 12, 31, 11, 31, 20, 13};

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pixel_count",  int'(pixel_count),  0);
    chk("reset_found",        int'(found),        0);
    chk("reset_centroid_x",   int'(centroid_x),   0);
    chk("reset_centroid_y",   int'(centroid_y),   0);
    chk("reset_result_valid", int'(result_valid), 0);
    chk("reset_overrun",      int'(overrun),      0);
    res = 1'b0;
    idle(2);

    // Empty pre-frame, then a 20x20 red square at cols 100..119, rows 200..219
    fs_exp(0, 0, 0, 0, 0, 1, 1'b0);
    for (int r = 0; r < 200; r++) eol();
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 120; c++) begin
        if (c >= 100) pix(9'd0, 1'b0, 5'd31, 5'd31);
        else          pix(9'd180, 1'b0, 5'd31, 5'd31);
      end
      eol();
    end
    fs_exp(400, 1, 109, 209, 0, 57, 1'b0);
    idle(60);

    // Hue wrap and S/V threshold pixels: 7 matches, below MIN_PIXELS
    for (int i = 0; i < 13; i++)
      pix(9'(hv[i]), 1'(iv[i]), 5'(sv[i]), 5'(vv[i]));
    // frame_start with a coincident red pixel: excluded here, (0,0) next frame
    fs_exp(7, 0, 0, 0, 0, 1, 1'b1);
    red_pixels(62);
    drive(1'b0, 1'b1, 1'b1, 9'd0, 1'b0, 5'd31, 5'd31);
    // 64 pixels at x=0..63, y=0 -> exactly MIN_PIXELS; overrun set below
    fs_exp(64, 1, 31, 0, 1, 57, 1'b0);
    red_pixels(9);
    drive(1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 5'd0, 5'd0);

    // Frame after the dropped frame_start: 64 pixels on row 3
    eol(); eol(); eol();
    red_pixels(64);
    idle(10);
    fs_exp(64, 1, 31, 3, 1, 57, 1'b0);
    idle(60);

    // Reset on cycle 20 of DIV_X: no result, outputs cleared
    red_pixels(64);
    drive(1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 5'd0, 5'd0);
    idle(19);
    #2;
    res = 1'b1;
    #1;
    chk("midres_pixel_count",  int'(pixel_count),  0);
    chk("midres_found",        int'(found),        0);
    chk("midres_centroid_x",   int'(centroid_x),   0);
    chk("midres_centroid_y",   int'(centroid_y),   0);
    chk("midres_result_valid", int'(result_valid), 0);
    chk("midres_overrun",      int'(overrun),      0);
    @(posedge clk);
    #1;
    res = 1'b0;
    idle(60);

    // Recovery after reset
    fs_exp(0, 0, 0, 0, 0, 1, 1'b0);
    red_pixels(64);
    fs_exp(64, 1, 31, 0, 0, 57, 1'b0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("pending_results", exp_q.size(), 0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
